// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline-boundary definitions: payload layouts, widths and
// control-bit positions used when instantiating pipe_stage_reg per boundary.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } id_ex_data_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } ex_mem_data_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic jal;
        logic branch;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
    } mem_wb_data_t;

    typedef struct packed {
        logic jal;
        logic mem_to_reg;
        logic reg_write;
    } mem_wb_ctrl_t;

    localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
    localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
    localparam int MEM_WB_CTRL_W = 3;

    localparam int MEM_WB_JAL      = 2;
    localparam int MEM_WB_MEMTOREG = 1;
    localparam int MEM_WB_REGWRITE = 0;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on i_clear, increments on i_inc, sticks at all-ones.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a two-entry (main + skid) buffer, flush
// and bubble-gated control. PIPE_STAGE_PERF_EN adds stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = MEM_WB_DATA_W,
    parameter int                CTRL_W   = MEM_WB_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              r_main_v;
    logic [DATA_W-1:0] r_main_d;
    logic [CTRL_W-1:0] r_main_c;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_skid_d;
    logic [CTRL_W-1:0] r_skid_c;

    logic w_acc;
    logic w_xfer;
    logic w_load;

    // in_ready depends only on held state (and reset), never on out_ready.
    assign in_ready = ~r_skid_v & ~reset;
    assign w_acc    = in_valid & in_ready;
    assign w_xfer   = r_main_v & out_ready;
    assign w_load   = ~r_main_v | w_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_v <= 1'b0;
            r_main_d <= '0;
            r_main_c <= CTRL_RST;
            r_skid_v <= 1'b0;
            r_skid_d <= '0;
            r_skid_c <= CTRL_RST;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (w_load) begin
            if (r_skid_v) begin
                r_main_v <= 1'b1;
                r_main_d <= r_skid_d;
                r_main_c <= r_skid_c;
                r_skid_v <= w_acc;
                if (w_acc) begin
                    r_skid_d <= in_data;
                    r_skid_c <= in_ctrl;
                end
            end else if (w_acc) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
                r_main_c <= in_ctrl;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (w_acc) begin
            // Main is stalled: park the new beat in the skid entry.
            r_skid_v <= 1'b1;
            r_skid_d <= in_data;
            r_skid_c <= in_ctrl;
        end
    end

    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign out_ctrl  = r_main_v ? r_main_c : CTRL_RST;

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall;

    assign w_stall = r_main_v & ~out_ready;

    sat_counter #(.W(32)) u_stall_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_stall),
        .o_cnt   (stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (flush),
        .o_cnt   (flush_cnt)
    );
`endif

endmodule
